// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-sharing arbiter.
// Holds the FSM state type and the round-robin search.
package reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of vec at or after start, wrapping at n,
  // skipping any bit set in excl.
  function automatic pick_t rr_find(
    input logic [15:0] vec,
    input logic [3:0]  start,
    input logic [15:0] excl,
    input int          n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      j = int'(start) + i;
      if (j >= n) j = j - n;
      if (!p.found && i < n && j < 16) begin
        if (vec[j] && !excl[j]) begin
          p.found = 1'b1;
          p.idx   = 4'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_reg.sv
// Shared storage register with synchronous clear.
// Write enable is formed upstream by feeding q back into d.
module reg_share_arbiter_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared pipeline register.
// Define ARB_PRIO_EN to add the prio input (priority subset).
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int MAX_HOLD  = 4,
  localparam int OWNER_W  = owner_w(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
`ifdef ARB_PRIO_EN
  input  logic [NREQ-1:0]           prio,
`endif
  input  logic [NREQ*DATAWIDTH-1:0] din,
  output logic [NREQ-1:0]           gnt,
  output logic [DATAWIDTH-1:0]      q,
  output logic                      q_valid,
  output logic [OWNER_W-1:0]        q_owner
);

  localparam int HOLD_W = owner_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                gap_q, gap_d;
  logic                q_valid_q;
  logic [OWNER_W-1:0]  q_owner_q;

  logic [NREQ-1:0]      cand;
  logic [NREQ-1:0]      excl;
  pick_t                pick;
  logic                 wr;
  logic [DATAWIDTH-1:0] reg_d;
  logic [DATAWIDTH-1:0] reg_q;

  always_comb begin
    cand = req;
`ifdef ARB_PRIO_EN
    if (|(req & prio)) cand = req & prio;
`endif
    excl = '0;
    if (state_q == OWN) excl = NREQ'(1) << owner_q;
    pick = rr_find(16'(cand), 4'(rr_ptr_q),
                   16'(excl), NREQ);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    gap_d    = 1'b0;
    wr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = OWN;
          owner_d = OWNER_W'(pick.idx);
          gnt_d   = NREQ'(1) << pick.idx;
          hold_d  = '0;
          rr_ptr_d = (int'(pick.idx) == NREQ - 1) ? '0 :
                     OWNER_W'(int'(pick.idx) + 1);
        end
      end
      OWN: begin
        if (gap_q) begin
          wr = 1'b0;
        end else if (req[owner_q]) begin
          wr = 1'b1;
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end else if (pick.found) begin
            // Last write of this term: hand over, new owner waits a cycle.
            owner_d = OWNER_W'(pick.idx);
            gnt_d   = NREQ'(1) << pick.idx;
            hold_d  = '0;
            gap_d   = 1'b1;
            rr_ptr_d = (int'(pick.idx) == NREQ - 1) ? '0 :
                       OWNER_W'(int'(pick.idx) + 1);
          end
        end else if (pick.found) begin
          owner_d = OWNER_W'(pick.idx);
          gnt_d   = NREQ'(1) << pick.idx;
          hold_d  = '0;
          rr_ptr_d = (int'(pick.idx) == NREQ - 1) ? '0 :
                     OWNER_W'(int'(pick.idx) + 1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      gap_q     <= 1'b0;
      q_valid_q <= 1'b0;
      q_owner_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      q_valid_q <= wr;
      if (wr) q_owner_q <= owner_q;
    end
  end

  assign reg_d = wr ?
    din[int'(owner_q)*DATAWIDTH +: DATAWIDTH] : reg_q;

  reg_share_arbiter_reg #(
    .W (DATAWIDTH)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .d   (reg_d),
    .q   (reg_q)
  );

  assign gnt     = gnt_q;
  assign q       = reg_q;
  assign q_valid = q_valid_q;
  assign q_owner = q_owner_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed plus random bench for reg_share_arbiter.
// Reference model works from ownership terms and write counts.
module tb_reg_share_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int MH = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      prio;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      gnt;
  logic [DW-1:0]     q;
  logic              q_valid;
  logic [1:0]        q_owner;

  int nassert;
  int nfail;

  // reference model state
  bit       m_busy;
  int       m_own;
  int       m_cnt;
  int       m_ptr;
  bit       m_gap;
  logic [DW-1:0] m_q;
  bit       m_qv;
  int       m_qo;

  reg_share_arbiter #(
    .DATAWIDTH (DW),
    .NREQ      (N),
    .MAX_HOLD  (MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef ARB_PRIO_EN
    .prio    (prio),
`endif
    .din     (din),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_owner (q_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] cand_set();
    logic [N-1:0] s;
    s = req;
`ifdef ARB_PRIO_EN
    if ((req & prio) != 0) s = req & prio;
`endif
    return s;
  endfunction

  function automatic int pick(input logic [N-1:0] s,
                              input int from, input int skip);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (from + k) % N;
      if (s[c] && c != skip) return c;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_own = w;
    m_ptr = (w + 1) % N;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int w;
    logic [N-1:0] s;
    s = cand_set();
    if (rst) begin
      m_busy = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
      m_gap = 0; m_q = '0; m_qv = 0; m_qo = 0;
    end else if (!m_busy) begin
      m_qv = 0;
      w = pick(s, m_ptr, -1);
      if (w >= 0) begin m_busy = 1; take(w); end
    end else if (m_gap) begin
      m_gap = 0;
      m_qv = 0;
    end else if (req[m_own]) begin
      m_q  = din[m_own*DW +: DW];
      m_qo = m_own;
      m_qv = 1;
      m_cnt++;
      if (m_cnt >= MH) begin
        w = pick(s, m_ptr, m_own);
        if (w >= 0) begin take(w); m_gap = 1; end
      end
    end else begin
      m_qv = 0;
      w = pick(s, m_ptr, m_own);
      if (w >= 0) take(w);
      else m_busy = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = m_busy ? (N'(1) << m_own) : '0;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("q", 64'(q), 64'(m_q));
    chk("q_valid", 64'(q_valid), 64'(m_qv));
    chk("q_owner", 64'(q_owner), 64'(m_qo));
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
  endtask

  initial begin
    int seq[$];
    int runs[$];
    int last;
    nassert = 0;
    nfail   = 0;
    prio    = '0;
    m_busy = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
    m_gap = 0; m_q = '0; m_qv = 0; m_qo = 0;

    // reset with noisy inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = N'($urandom);
      rand_din();
      step();
    end
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_gnt", 64'(gnt), 64'(0));

    // single requester, no rotation
    rst = 1'b0;
    req = 4'b0100;
    din = '0;
    for (int k = 0; k < 10; k++) begin
      din[2*DW +: DW] = 32'hA5A5_0001 + 32'(k);
      step();
      if (k == 0) chk("single_gnt", 64'(gnt), 64'h4);
    end
    chk("single_owner", 64'(q_owner), 64'd2);
    chk("single_q", 64'(q), 64'hA5A5_000A);

    // all requesting: strict rotation order
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 4'b1111;
    last = -1;
    for (int k = 0; k < 25; k++) begin
      rand_din();
      step();
      if (q_valid) begin
        if (int'(q_owner) != last) begin
          seq.push_back(int'(q_owner));
          runs.push_back(1);
          last = int'(q_owner);
        end else begin
          runs[runs.size()-1]++;
        end
      end
    end
    chk("rr_nruns", 64'(seq.size()), 64'd5);
    if (seq.size() == 5) begin
      for (int i = 0; i < 5; i++)
        chk("rr_order", 64'(seq[i]), 64'(i % N));
      for (int i = 0; i < 4; i++)
        chk("rr_len", 64'(runs[i]), 64'(MH));
    end

    // release hands straight to the next requester
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 4'b1010;
    for (int k = 0; k < 3; k++) begin rand_din(); step(); end
    req = 4'b1000;
    step();
    chk("release_gnt", 64'(gnt), 64'h8);
    step();
    chk("release_owner", 64'(q_owner), 64'd3);

    // reset while owning discards the write
    rand_din();
    rst = 1'b1;
    step();
    chk("midrst_q", 64'(q), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("midrst_rr", 64'(gnt), 64'h1);

`ifdef ARB_PRIO_EN
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 4'b1111; prio = 4'b0100;
    for (int k = 0; k < 12; k++) begin rand_din(); step(); end
    chk("prio_hold", 64'(gnt), 64'h4);
    prio = '0;
    for (int k = 0; k < 3; k++) begin rand_din(); step(); end
    chk("prio_resume", 64'(gnt), 64'h8);
`endif

    // random traffic
    rst = 1'b1; req = '0; step();
    rst = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(N-1)] ^= 1'b1;
`ifdef ARB_PRIO_EN
      if ($urandom_range(15) == 0) prio = N'($urandom);
`endif
      rst = ($urandom_range(79) == 0);
      rand_din();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
